// File: rtl/packet_deframer.sv
// UART command-path framer: hunts SYNC_BYTE, parses Dest/Src/Len header
// and emits payload bytes as a UART_PACKET stream with SoP/EoP marking.
//
// Ports:
//   ipClk      in   system clock, rising edge
//   ipReset    in   asynchronous active-low reset
//   ipRxData   in   received byte, qualified by ipRxValid
//   ipRxValid  in   one-cycle strobe per received byte
//   opRxStream out  registered payload beat plus latched header fields
//   opError    out  one-cycle pulse on inter-byte timeout abort

package uart_pkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

module packet_deframer
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [7:0] ipRxData,
    input  logic       ipRxValid,
    output UART_PACKET opRxStream,
    output logic       opError
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_SYNC,
        S_DEST,
        S_SRC,
        S_LEN,
        S_DATA
    } state_t;

    state_t        state_q;
    logic [7:0]    rem_q;
    logic [TW-1:0] tmo_q;
    logic          first_q;
    UART_PACKET    out_q;
    logic          err_q;
    logic          expire;

    // TIMEOUT idle cycles have elapsed when the counter already holds
    // TIMEOUT-1 and this cycle brings no byte either; a byte always wins.
    assign expire = (state_q != S_SYNC) && !ipRxValid
                    && (tmo_q >= TMO_LAST);

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q <= S_SYNC;
            rem_q   <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q.Valid <= 1'b0;
            out_q.SoP   <= 1'b0;
            out_q.EoP   <= 1'b0;
            err_q       <= 1'b0;

            if (state_q == S_SYNC || ipRxValid) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_MAX) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (expire) begin
                err_q   <= 1'b1;
                state_q <= S_SYNC;
                tmo_q   <= '0;
            end else if (ipRxValid) begin
                unique case (state_q)
                    S_SYNC: begin
                        if (ipRxData == SYNC_BYTE) begin
                            state_q <= S_DEST;
                        end
                    end
                    S_DEST: begin
                        out_q.Destination <= ipRxData;
                        state_q           <= S_SRC;
                    end
                    S_SRC: begin
                        out_q.Source <= ipRxData;
                        state_q      <= S_LEN;
                    end
                    S_LEN: begin
                        out_q.Length <= ipRxData;
                        rem_q        <= ipRxData;
                        first_q      <= 1'b1;
                        // Zero-length frames are dropped without output.
                        state_q <= (ipRxData == 8'd0) ? S_SYNC : S_DATA;
                    end
                    S_DATA: begin
                        out_q.Data  <= ipRxData;
                        out_q.Valid <= 1'b1;
                        out_q.SoP   <= first_q;
                        out_q.EoP   <= (rem_q == 8'd1);
                        first_q     <= 1'b0;
                        rem_q       <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q <= S_SYNC;
                        end
                    end
                    default: state_q <= S_SYNC;
                endcase
            end
        end
    end

    assign opRxStream = out_q;
    assign opError    = err_q;

endmodule
